uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver.
- Consumes the 16x-oversample enable pulse from the baud-rate generator (the rx_clk output, a 1-cycle strobe at 50 MHz / (115200*16)).
- Synchronises the asynchronous serial line, finds the start bit, samples each bit at mid-period, and presents the received byte with a one-cycle valid strobe.
- Sits between the pad and the byte-level consumer (loopback/echo logic or a FIFO).

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first.
- OVERSAMPLE, 16, rx_tick pulses per bit period; must be a power of 2 and ≥ 8.
- CNT_W, $clog2(OVERSAMPLE), width of the tick counter.

Ports:
- clk50  input  1  50 MHz system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_tick  input  1  16x-oversample enable from the baud generator; 1-cycle pulse; not a clock.
- rx  input  1  raw serial line, asynchronous, idle high.
- data  output  DATA_BITS  last good byte; holds its value until the next good frame.
- valid  output  1  1-cycle pulse when data has just been updated.
- frame_err  output  1  1-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: data = 0, valid = 0, frame_err = 0, busy = 0, state = IDLE, counters = 0, synchroniser flops = 1.
- Reset is async assert, sync release. Reset mid-frame aborts the frame; no valid and no frame_err.
- Synchroniser: two flops on rx, giving rx_s. All decisions use rx_s only, so there are 2 cycles of input latency.
- State, tick counter and bit counter advance only in cycles where rx_tick = 1. valid and frame_err are ordinary registered outputs.
- IDLE: on a tick with rx_s = 0 -> START, tick counter cnt = 0.
- START:
  - Each tick, cnt++.
  - On the tick where cnt == OVERSAMPLE/2-1 (7): if rx_s = 0 -> DATA, cnt = 0, bit = 0.
  - Otherwise it is a glitch -> IDLE, with no output pulse.
- DATA:
  - Each tick, cnt++.
  - On the tick where cnt == OVERSAMPLE-1: shift rx_s into the MSB of the shift register (right shift, so LSB-first arrival lands correctly), cnt = 0, bit++.
  - After bit DATA_BITS-1 is sampled -> STOP.
- STOP: each tick, cnt++. On the tick where cnt == OVERSAMPLE-1:
  - rx_s = 1: data <= shift register, valid = 1 for exactly the next clk50 cycle, -> IDLE.
  - rx_s = 0: frame_err = 1 for one cycle, data unchanged, -> BREAK.
- BREAK: stays there until a tick with rx_s = 1, then -> IDLE. A held-low line (break) therefore gives exactly one frame_err, not repeated false frames.
- Sampling points are mid-bit ±1 tick. Tolerated baud mismatch is ≥ ±3% over a frame.
- Back-to-back frames: the next start edge may arrive on the tick immediately after the stop sample. IDLE must accept it with no dead tick.
- Counter widths:
  - cnt is CNT_W bits and wraps naturally.
  - bit is $clog2(DATA_BITS)+1 bits.
  - No arithmetic overflow is reachable.
- rx_tick held high continuously is legal; the block simply runs at clk50 rate.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - constants DATA_BITS = 8, OVERSAMPLE = 16, CLK_HZ = 50_000_000, BAUD = 115200.
- The baud generator and the future transmitter share this package.
- One sub-module: sync2, a generic 2-flop synchroniser with reset value parameter = 1, reused later by other pad inputs.
- FSM and shifter stay in uart_rx.

Test Plan:
- Bench drives rx_tick every 4 cycles, so 1 bit = 64 cycles. Send 0x55, stop = 1 -> one valid pulse, data = 0x55, frame_err never asserted, busy low afterwards.
- Send 0xA5 then 0x3C back-to-back, no idle gap -> two valid pulses, 160 ticks apart, with data = 0xA5 then 0x3C.
- rx low for 3 ticks then high -> returns to IDLE at the mid-start check; no valid, no frame_err, data keeps its previous value.
- Send 0xF0 with stop bit = 0, then line high -> one frame_err pulse, no valid, data unchanged.
- Hold rx low for 40 bit times (break), then high, then send 0x81 -> exactly one frame_err; 0x81 then received with valid.
- Assert rst_n low during data bit 4 of 0xFF, release, send 0x12 -> outputs at reset values during reset; no pulse from the aborted frame; data = 0x12 with valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver, transmitter and baud generator.
// Frame format, oversampling ratio, clocking constants and receiver states.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 115200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

endpackage

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchroniser for asynchronous pad inputs.
// RST_VAL sets the flop value held while in reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversample enable strobe.
// Emits a one-cycle valid per good byte, or frame_err per bad stop bit.
module uart_rx #(
  parameter int DATA_BITS  = uart_pkg::DATA_BITS,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic                 clk50,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int BIT_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_B  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk50),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (rx_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == FULL_M1) begin
            // LSB arrives first, so shift right from the top
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_B) begin
              state_d = STOP;
            end
          end
        end
        STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == FULL_M1) begin
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 cycles, 64 cycles per bit.
// Monitors valid/frame_err pulses and checks against hand-computed values.
module tb_uart_rx;

  localparam int BITC = 64;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int vcnt = 0;
  int fcnt = 0;
  logic [7:0] vlog [0:7];
  int         vcyc [0:7];

  uart_rx dut (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .rx_tick   (rx_tick),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk50 = ~clk50;

  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk50);
      rx_tick = (k == 3);
      k = (k + 1) % 4;
    end
  end

  initial begin
    forever begin
      @(negedge clk50);
      cyc = cyc + 1;
      if (rst_n && valid) begin
        if (vcnt < 8) begin
          vlog[vcnt] = data;
          vcyc[vcnt] = cyc;
        end
        vcnt = vcnt + 1;
      end
      if (rst_n && frame_err) fcnt = fcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BITC) @(negedge clk50);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * BITC) @(negedge clk50);
  endtask

  task automatic clr;
    vcnt = 0;
    fcnt = 0;
  endtask

  initial begin
    repeat (5) @(negedge clk50);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(2);

    clr();
    send(8'h55, 1'b1);
    idle(2);
    check("t1_vcnt", 32'(vcnt), 1);
    check("t1_data", 32'(vlog[0]), 32'h55);
    check("t1_ferr", 32'(fcnt), 0);
    check("t1_busy", 32'(busy), 0);

    clr();
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    idle(2);
    check("t2_vcnt", 32'(vcnt), 2);
    check("t2_d0", 32'(vlog[0]), 32'hA5);
    check("t2_d1", 32'(vlog[1]), 32'h3C);
    check("t2_gap", 32'(vcyc[1] - vcyc[0]), 640);
    check("t2_ferr", 32'(fcnt), 0);

    clr();
    rx = 1'b0;
    repeat (12) @(negedge clk50);
    idle(2);
    check("t3_vcnt", 32'(vcnt), 0);
    check("t3_ferr", 32'(fcnt), 0);
    check("t3_data", 32'(data), 32'h3C);
    check("t3_busy", 32'(busy), 0);

    clr();
    send(8'hF0, 1'b0);
    idle(2);
    check("t4_ferr", 32'(fcnt), 1);
    check("t4_vcnt", 32'(vcnt), 0);
    check("t4_data", 32'(data), 32'h3C);
    check("t4_busy", 32'(busy), 0);

    clr();
    rx = 1'b0;
    repeat (40 * BITC) @(negedge clk50);
    idle(2);
    check("t5_ferr1", 32'(fcnt), 1);
    send(8'h81, 1'b1);
    idle(2);
    check("t5_ferr", 32'(fcnt), 1);
    check("t5_vcnt", 32'(vcnt), 1);
    check("t5_data", 32'(vlog[0]), 32'h81);

    clr();
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (4 * BITC + BITC / 2) @(negedge clk50);
    check("t6_busy_mid", 32'(busy), 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk50);
    check("t6_rst_data", 32'(data), 32'h00);
    check("t6_rst_valid", 32'(valid), 0);
    check("t6_rst_ferr", 32'(frame_err), 0);
    check("t6_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(6);
    check("t6_abort_v", 32'(vcnt), 0);
    send(8'h12, 1'b1);
    idle(2);
    check("t6_vcnt", 32'(vcnt), 1);
    check("t6_data", 32'(vlog[0]), 32'h12);
    check("t6_ferr", 32'(fcnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
